load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 192 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit bridging CPU byte/halfword/word accesses onto a word-wide DataMemory.
// Sub-word stores use read-modify-write; every output is driven straight from a flop.
module load_store_unit #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        startin,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] ReadData
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] LAT_LAST = 4'(READ_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sign_ext_q, sign_ext_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [15:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;

  logic        req_misaligned;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  always_comb begin
    req_misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
  end

  // Lane extraction for loads and lane replacement for read-modify-write stores.
  always_comb begin
    lane_byte = ReadData[{addr_lo_q, 3'b000} +: 8];
    lane_half = ReadData[{addr_lo_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = {{24{sign_ext_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{16{sign_ext_q & lane_half[15]}}, lane_half};
      default: load_ext = ReadData;
    endcase
    merged = ReadData;
    if (size_q == 2'b00) merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    size_d       = size_q;
    sign_ext_d   = sign_ext_q;
    addr_lo_d    = addr_lo_q;
    wdata_d      = wdata_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rdata_d      = rdata_q;
    misaligned_d = misaligned_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    mem_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d         = we;
          size_d       = size;
          sign_ext_d   = sign_ext;
          addr_lo_d    = addr[1:0];
          wdata_d      = wdata[15:0];
          misaligned_d = req_misaligned;
          busy_d       = 1'b1;
          if (req_misaligned) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            address_d = {2'b00, addr[31:2]};
            if (we && size[1]) begin
              state_d      = WRITE;
              mem_write_d  = 1'b1;
              write_data_d = wdata;
            end else begin
              state_d    = READ;
              mem_read_d = 1'b1;
              cnt_d      = LAT_LAST;
            end
          end
        end
      end
      READ: begin
        // ReadData is consumed on the edge that ends the last READ cycle.
        if (cnt_q == 4'd0) begin
          if (we_q) begin
            state_d      = WRITE;
            mem_write_d  = 1'b1;
            write_data_d = merged;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            rdata_d = load_ext;
          end
        end else begin
          cnt_d      = cnt_q - 4'd1;
          mem_read_d = 1'b1;
        end
      end
      WRITE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sign_ext_q   <= 1'b0;
      addr_lo_q    <= 2'b00;
      wdata_q      <= 16'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdata_q      <= 32'd0;
      misaligned_q <= 1'b0;
      address_q    <= 32'd0;
      write_data_q <= 32'd0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sign_ext_q   <= sign_ext_d;
      addr_lo_q    <= addr_lo_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign misaligned = misaligned_q;
  assign Address    = address_q;
  assign WriteData  = write_data_q;
  assign MemWrite   = mem_write_q;
  assign MemRead    = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (READ_LAT 1 and 3) with private word memories,
// a transaction-level timing model checked every cycle, and directed literal checks.
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        req_v [2];
  logic        startin_v [2];
  logic        we, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy_v [2];
  logic        done_v [2];
  logic        mis_v [2];
  logic        mw_v [2];
  logic        mr_v [2];
  logic [31:0] rdata_v [2];
  logic [31:0] address_v [2];
  logic [31:0] wdo_v [2];
  logic [31:0] rd_v [2];

  logic        pl_en;
  logic        pl_inst;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;
  logic        chk_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.READ_LAT(1)) dut0 (
    .clk(clk), .startin(startin_v[0]), .req(req_v[0]), .we(we), .size(size),
    .sign_ext(sext), .addr(addr), .wdata(wdata), .busy(busy_v[0]), .done(done_v[0]),
    .rdata(rdata_v[0]), .misaligned(mis_v[0]), .Address(address_v[0]),
    .WriteData(wdo_v[0]), .MemWrite(mw_v[0]), .MemRead(mr_v[0]), .ReadData(rd_v[0])
  );

  load_store_unit #(.READ_LAT(3)) dut1 (
    .clk(clk), .startin(startin_v[1]), .req(req_v[1]), .we(we), .size(size),
    .sign_ext(sext), .addr(addr), .wdata(wdata), .busy(busy_v[1]), .done(done_v[1]),
    .rdata(rdata_v[1]), .misaligned(mis_v[1]), .Address(address_v[1]),
    .WriteData(wdo_v[1]), .MemWrite(mw_v[1]), .MemRead(mr_v[1]), .ReadData(rd_v[1])
  );

  // DataMemory stand-ins: combinational read, write on the strobe, plus a preload port.
  logic [31:0] mem [2][16];
  assign rd_v[0] = mem[0][address_v[0][3:0]];
  assign rd_v[1] = mem[1][address_v[1][3:0]];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (mw_v[i]) mem[i][address_v[i][3:0]] <= wdo_v[i];
    if (pl_en) mem[pl_inst][pl_idx] <= pl_val;
  end

  function automatic int rl(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Transaction model: each accepted request becomes a schedule of edge offsets and results.
  int          ecnt = 0;
  int          acc [2];
  int          lat [2];
  int          woff [2];
  int          idle_from [2] = '{0, 0};
  bit          valid [2];
  bit          reads [2];
  bit          writes [2];
  bit          is_load [2];
  bit          e_mis [2];
  logic [31:0] wword [2];
  logic [31:0] ldres [2];
  logic [31:0] e_rdata [2];
  logic [31:0] e_address [2];
  logic [31:0] e_wdata [2];
  logic [31:0] m_mem [2][16];

  always @(posedge clk) begin
    logic [31:0] w, lane, mask;
    int sh;
    bit mis;
    ecnt++;
    if (pl_en) m_mem[pl_inst][pl_idx] = pl_val;
    for (int i = 0; i < 2; i++) begin
      if (startin_v[i]) begin
        valid[i] = 0; e_mis[i] = 0;
        e_rdata[i] = 0; e_address[i] = 0; e_wdata[i] = 0;
        idle_from[i] = ecnt + 1;
      end else begin
        if (req_v[i] && ecnt >= idle_from[i]) begin
          mis = ((size == 2'b01) && addr[0]) || ((size >= 2'b10) && (addr[1:0] != 2'b00));
          w = m_mem[i][addr[5:2]];
          acc[i] = ecnt; valid[i] = 1; e_mis[i] = mis;
          reads[i] = 0; writes[i] = 0; is_load[i] = 0; woff[i] = 0;
          sh = (size == 2'b00) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
          mask = (size == 2'b00) ? (32'hFF << sh) : (32'hFFFF << sh);
          if (mis) lat[i] = 1;
          else begin
            e_address[i] = {2'b00, addr[31:2]};
            if (!we) begin
              is_load[i] = 1; reads[i] = 1; lat[i] = 1 + rl(i);
              lane = (w & mask) >> sh;
              if (size >= 2'b10) ldres[i] = w;
              else if (size == 2'b00) ldres[i] = (sext && lane >= 32'h80) ? (lane | 32'hFFFFFF00) : lane;
              else ldres[i] = (sext && lane >= 32'h8000) ? (lane | 32'hFFFF0000) : lane;
            end else if (size >= 2'b10) begin
              writes[i] = 1; lat[i] = 2; wword[i] = wdata;
            end else begin
              reads[i] = 1; writes[i] = 1; woff[i] = rl(i); lat[i] = 2 + rl(i);
              wword[i] = (w & ~mask) | ((wdata << sh) & mask);
            end
          end
          idle_from[i] = ecnt + lat[i] + 1;
        end
        if (valid[i] && writes[i] && ecnt == acc[i] + woff[i]) begin
          e_wdata[i] = wword[i];
          m_mem[i][e_address[i][3:0]] = wword[i];
        end
        if (valid[i] && is_load[i] && ecnt == acc[i] + rl(i)) e_rdata[i] = ldres[i];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Per-cycle comparison against the model, plus strobe counters used by the directed tests.
  int mr_cnt [2] = '{0, 0};
  int mw_cnt [2] = '{0, 0};
  int mw_rise [2] = '{0, 0};
  bit mw_prev [2] = '{0, 0};

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int d;
        d = ecnt - acc[i];
        checkOutput($sformatf("dut%0d busy", i), 32'(busy_v[i]), 32'(valid[i] && d < lat[i]));
        checkOutput($sformatf("dut%0d done", i), 32'(done_v[i]), 32'(valid[i] && d == lat[i] - 1));
        checkOutput($sformatf("dut%0d MemRead", i), 32'(mr_v[i]), 32'(valid[i] && reads[i] && d < rl(i)));
        checkOutput($sformatf("dut%0d MemWrite", i), 32'(mw_v[i]), 32'(valid[i] && writes[i] && d == woff[i]));
        checkOutput($sformatf("dut%0d misaligned", i), 32'(mis_v[i]), 32'(e_mis[i]));
        checkOutput($sformatf("dut%0d rdata", i), rdata_v[i], e_rdata[i]);
        checkOutput($sformatf("dut%0d Address", i), address_v[i], e_address[i]);
        checkOutput($sformatf("dut%0d WriteData", i), wdo_v[i], e_wdata[i]);
        mr_cnt[i] += int'(mr_v[i]);
        mw_cnt[i] += int'(mw_v[i]);
        if (mw_v[i] && !mw_prev[i]) mw_rise[i]++;
        mw_prev[i] = mw_v[i];
      end
    end
  end

  task automatic setWord(input int inst, input int idx, input logic [31:0] val);
    pl_inst = 1'(inst); pl_idx = 4'(idx); pl_val = val; pl_en = 1'b1;
    @(posedge clk); #2;
    pl_en = 1'b0;
  endtask

  // Issues one request, returns req-edge-to-done latency, and leaves the unit idle.
  task automatic applyStimulus(input int inst, input logic w, input logic [1:0] sz, input logic se,
                               input logic [31:0] a, input logic [31:0] wd, output int l);
    we = w; size = sz; sext = se; addr = a; wdata = wd;
    req_v[inst] = 1'b1;
    @(posedge clk); #2;
    req_v[inst] = 1'b0;
    l = 1;
    while (!done_v[inst] && l < 40) begin
      @(posedge clk); #2;
      l++;
    end
    checkOutput($sformatf("dut%0d done seen", inst), 32'(done_v[inst]), 32'd1);
    @(posedge clk); #2;
  endtask

  initial begin
    int l, mr0, mw0, rise0;
    req_v[0] = 0; req_v[1] = 0; startin_v[0] = 1; startin_v[1] = 1;
    we = 0; size = 0; sext = 0; addr = 0; wdata = 0;
    pl_en = 0; pl_inst = 0; pl_idx = 0; pl_val = 0;
    repeat (2) @(posedge clk);
    #2;
    startin_v[0] = 0; startin_v[1] = 0;
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset busy", 32'(busy_v[i]), 32'd0);
      checkOutput("reset MemRead", 32'(mr_v[i]), 32'd0);
      checkOutput("reset Address", address_v[i], 32'd0);
      checkOutput("reset rdata", rdata_v[i], 32'd0);
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++) setWord(i, j, 32'd0);
    setWord(0, 2, 32'h000000A5);
    setWord(0, 1, 32'h11223344);
    setWord(1, 0, 32'h80010000);
    setWord(1, 5, 32'hCAFEF00D);

    // lb, sign-extended, READ_LAT=1
    mr0 = mr_cnt[0]; mw0 = mw_cnt[0];
    applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h8, 32'h0, l);
    checkOutput("lb latency", 32'(l), 32'd2);
    checkOutput("lb MemRead cycles", 32'(mr_cnt[0] - mr0), 32'd1);
    checkOutput("lb Address", address_v[0], 32'd2);
    checkOutput("lb rdata", rdata_v[0], 32'hFFFFFFA5);

    // sh into upper lane: read-modify-write
    mr0 = mr_cnt[0]; mw0 = mw_cnt[0];
    applyStimulus(0, 1'b1, 2'b01, 1'b0, 32'h6, 32'h0000BEEF, l);
    checkOutput("sh latency", 32'(l), 32'd3);
    checkOutput("sh MemRead cycles", 32'(mr_cnt[0] - mr0), 32'd1);
    checkOutput("sh MemWrite cycles", 32'(mw_cnt[0] - mw0), 32'd1);
    checkOutput("sh WriteData", wdo_v[0], 32'hBEEF3344);
    checkOutput("sh memory", mem[0][1], 32'hBEEF3344);

    // misaligned lw
    mr0 = mr_cnt[0]; mw0 = mw_cnt[0];
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h0000000A, 32'h0, l);
    checkOutput("mis latency", 32'(l), 32'd1);
    checkOutput("mis flag", 32'(mis_v[0]), 32'd1);
    checkOutput("mis strobes", 32'((mr_cnt[0] - mr0) + (mw_cnt[0] - mw0)), 32'd0);
    checkOutput("mis rdata kept", rdata_v[0], 32'hFFFFFFA5);

    // lbu of top byte, lh sign-extended
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h7, 32'h0, l);
    checkOutput("lbu rdata", rdata_v[0], 32'h000000BE);
    checkOutput("lbu mis cleared", 32'(mis_v[0]), 32'd0);
    applyStimulus(0, 1'b0, 2'b01, 1'b1, 32'h6, 32'h0, l);
    checkOutput("lh rdata", rdata_v[0], 32'hFFFFBEEF);

    // req held through two word stores (second uses size 11)
    mw0 = mw_cnt[0]; rise0 = mw_rise[0];
    we = 1; size = 2'b10; sext = 0; addr = 32'h10; wdata = 32'h12345678;
    req_v[0] = 1'b1;
    @(posedge clk); #2;
    wdata = 32'h9ABCDEF0; size = 2'b11;
    repeat (3) @(posedge clk);
    #2;
    req_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("sw pair MemWrite cycles", 32'(mw_cnt[0] - mw0), 32'd2);
    checkOutput("sw pair pulses", 32'(mw_rise[0] - rise0), 32'd2);
    checkOutput("sw pair memory", mem[0][4], 32'h9ABCDEF0);

    // READ_LAT=3: lhu, then a full sb
    mr0 = mr_cnt[1];
    applyStimulus(1, 1'b0, 2'b01, 1'b0, 32'h2, 32'h0, l);
    checkOutput("lhu latency", 32'(l), 32'd4);
    checkOutput("lhu MemRead cycles", 32'(mr_cnt[1] - mr0), 32'd3);
    checkOutput("lhu rdata", rdata_v[1], 32'h00008001);
    applyStimulus(1, 1'b1, 2'b00, 1'b0, 32'h15, 32'h00000077, l);
    checkOutput("sb latency", 32'(l), 32'd5);
    checkOutput("sb WriteData", wdo_v[1], 32'hCAFE770D);

    // reset in the middle of a sb read phase, with req asserted on the same edge
    mw0 = mw_cnt[1];
    we = 1; size = 2'b00; addr = 32'h14; wdata = 32'h55;
    req_v[1] = 1'b1;
    @(posedge clk); #2;
    req_v[1] = 1'b0;
    @(posedge clk); #2;
    checkOutput("abort in READ", 32'(mr_v[1]), 32'd1);
    startin_v[1] = 1'b1; req_v[1] = 1'b1;
    @(posedge clk); #2;
    startin_v[1] = 1'b0; req_v[1] = 1'b0;
    checkOutput("abort busy", 32'(busy_v[1]), 32'd0);
    checkOutput("abort MemRead", 32'(mr_v[1]), 32'd0);
    checkOutput("abort rdata", rdata_v[1], 32'd0);
    checkOutput("abort WriteData", wdo_v[1], 32'd0);
    repeat (5) @(posedge clk);
    #2;
    checkOutput("abort MemWrite cycles", 32'(mw_cnt[1] - mw0), 32'd0);
    checkOutput("abort memory", mem[1][5], 32'hCAFE770D);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
